// File: rtl/goertzel_pkg.sv
// Shared types and widths for the Goertzel scheduler and its datapath.
package goertzel_pkg;

  localparam int MIC_W          = 12;
  localparam int Y_W            = 61;
  localparam int COEF_W_DEFAULT = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_SETTLE,
    ST_OUTPUT
  } gz_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle sample tick every CLK_DIV clocks.
module sample_tick_gen
  import goertzel_pkg::*;
#(
  parameter int CLK_DIV = 5000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_p0;

  assign tick = (cnt_p0 == CW'(CLK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_p0 <= '0;
    end else if (tick) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

endmodule

// File: rtl/goertzel_sched.sv
// Round-robin Goertzel block scheduler: paces samples into an external datapath
// and hands out one result per bin. Optional drop counter: GZ_SCHED_DROP_CNT_EN.
module goertzel_sched
  import goertzel_pkg::*;
#(
  parameter int CLK_DIV    = 5000,
  parameter int N_SAMPLES  = 205,
  parameter int N_BINS     = 8,
  parameter int SETTLE_CYC = 2,
  parameter int COEF_W     = COEF_W_DEFAULT,
  localparam int BIN_W     = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  output logic              busy,
  input  logic [MIC_W-1:0]  mic_in,
  output logic [MIC_W-1:0]  mic_out,
  output logic              gz_clr,
  output logic              gz_step,
  output logic [COEF_W-1:0] gz_coef,
  input  logic [Y_W-1:0]    gz_y1,
  input  logic [Y_W-1:0]    gz_y2,
  input  logic              coef_we,
  input  logic [BIN_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [BIN_W-1:0]  res_bin,
  output logic [Y_W-1:0]    res_y1,
  output logic [Y_W-1:0]    res_y2
`ifdef GZ_SCHED_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int TBL_D  = 1 << BIN_W;
  localparam int SCNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int SCYC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  gz_state_e           state, state_nxt;
  logic                tick_p0;
  logic                hs;
  logic                step_p0;
  logic                last_step;
  logic                settle_done;
  logic [BIN_W-1:0]    bin, bin_nxt;
  logic [SCNT_W-1:0]   scnt;
  logic [SCYC_W-1:0]   scyc;
  logic [COEF_W-1:0]   tbl [TBL_D];

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick_p0)
  );

  assign hs          = (state == ST_OUTPUT) && res_ready;
  assign step_p0     = (state == ST_ACCUM) && tick_p0;
  assign last_step   = step_p0 && (scnt == SCNT_W'(N_SAMPLES - 1));
  assign settle_done = (state == ST_SETTLE) && (scyc == SCYC_W'(SETTLE_CYC - 1));
  assign busy        = (state != ST_IDLE);
  assign gz_clr      = (state == ST_CLEAR);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (en) state_nxt = ST_CLEAR;
      ST_CLEAR:  state_nxt = ST_ACCUM;
      ST_ACCUM:  if (last_step) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (hs) state_nxt = en ? ST_CLEAR : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bin_nxt = bin;
    if (hs) begin
      bin_nxt = (bin == BIN_W'(N_BINS - 1)) ? '0 : bin + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      bin   <= '0;
      scnt  <= '0;
      scyc  <= '0;
    end else begin
      state <= state_nxt;
      bin   <= bin_nxt;
      if (step_p0) begin
        scnt <= last_step ? '0 : scnt + 1'b1;
      end
      scyc <= ((state == ST_SETTLE) && !settle_done) ? scyc + 1'b1 : '0;
    end
  end

  // Table writes land one cycle later; the active coefficient is only
  // sampled on entry to CLEAR, so mid-block writes wait for the next block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < TBL_D; i++) begin
        tbl[i] <= '0;
      end
    end else if (coef_we) begin
      tbl[coef_addr] <= coef_wdata;
    end
  end

  // Stage p1: sample/step strobe and coefficient, visible the cycle after the decision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mic_out <= '0;
      gz_step <= 1'b0;
      gz_coef <= '0;
    end else begin
      gz_step <= step_p0;
      if (step_p0) begin
        mic_out <= mic_in;
      end
      if ((state_nxt == ST_CLEAR) && (state != ST_CLEAR)) begin
        gz_coef <= tbl[bin_nxt];
      end
    end
  end

  // Stage p2: result capture held until the consumer accepts it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_valid <= 1'b0;
      res_bin   <= '0;
      res_y1    <= '0;
      res_y2    <= '0;
    end else if (settle_done) begin
      res_valid <= 1'b1;
      res_bin   <= bin;
      res_y1    <= gz_y1;
      res_y2    <= gz_y2;
    end else if (hs) begin
      res_valid <= 1'b0;
    end
  end

`ifdef GZ_SCHED_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] drop_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_q <= '0;
    end else if (tick_p0 && en && (state != ST_ACCUM)) begin
      drop_q <= sat_inc16(drop_q);
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_goertzel_sched.sv
// Directed bench for goertzel_sched with a small datapath model driving gz_y1/gz_y2.
module tb_goertzel_sched;

  localparam int CLK_DIV    = 4;
  localparam int N_SAMPLES  = 3;
  localparam int N_BINS     = 2;
  localparam int SETTLE_CYC = 2;
  localparam int COEF_W     = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              busy;
  logic [11:0]       mic_in;
  logic [11:0]       mic_out;
  logic              gz_clr;
  logic              gz_step;
  logic [COEF_W-1:0] gz_coef;
  logic [60:0]       gz_y1;
  logic [60:0]       gz_y2;
  logic              coef_we;
  logic [0:0]        coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              res_valid;
  logic              res_ready;
  logic [0:0]        res_bin;
  logic [60:0]       res_y1;
  logic [60:0]       res_y2;
`ifdef GZ_SCHED_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  always #5 clk = ~clk;

  goertzel_sched #(
    .CLK_DIV    (CLK_DIV),
    .N_SAMPLES  (N_SAMPLES),
    .N_BINS     (N_BINS),
    .SETTLE_CYC (SETTLE_CYC),
    .COEF_W     (COEF_W)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .en         (en),
    .busy       (busy),
    .mic_in     (mic_in),
    .mic_out    (mic_out),
    .gz_clr     (gz_clr),
    .gz_step    (gz_step),
    .gz_coef    (gz_coef),
    .gz_y1      (gz_y1),
    .gz_y2      (gz_y2),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_bin    (res_bin),
    .res_y1     (res_y1),
    .res_y2     (res_y2)
`ifdef GZ_SCHED_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  int          n_asrt = 0;
  int          n_fail = 0;
  int          ncyc   = 0;
  logic [60:0] y1m = '0;
  logic [60:0] y2m = '0;
  logic        pend_clr  = 1'b0;
  logic        pend_step = 1'b0;
  logic [11:0] pend_mic  = '0;

  function automatic logic [11:0] mic_val(input int c);
    return 12'(c * 37 + 5);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: the datapath model applies last cycle's clr/step, then new inputs are driven.
  task automatic cyc();
    @(negedge clk);
    ncyc++;
    if (pend_clr) begin
      y1m = '0;
      y2m = '0;
    end else if (pend_step) begin
      y2m = y1m;
      y1m = y1m + {49'd0, pend_mic} + 61'h0AB0_0000_0001;
    end
    pend_clr  = gz_clr;
    pend_step = gz_step;
    pend_mic  = mic_out;
    gz_y1     = y1m;
    gz_y2     = y2m;
    mic_in    = mic_val(ncyc);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return gz_clr;
      1:       return gz_step;
      default: return res_valid;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (sel(which)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic ok;
    int   prev;
    int   nsteps;

    rst = 1'b1; en = 1'b0; res_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    mic_in = '0; gz_y1 = '0; gz_y2 = '0;
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_clr", gz_clr, 0);
    chk("rst_step", gz_step, 0);
    chk("rst_coef", gz_coef, 0);
    chk("rst_mic", mic_out, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_bin", res_bin, 0);
    chk("rst_y1", res_y1, 0);
    chk("rst_y2", res_y2, 0);
`ifdef GZ_SCHED_DROP_CNT_EN
    chk("rst_drop", drop_cnt, 0);
`endif

    rst = 1'b0;
    coef_we = 1'b1; coef_addr = 1'b0; coef_wdata = 18'h01234;
    cyc();
    coef_addr = 1'b1; coef_wdata = 18'h00ABC;
    cyc();
    coef_we = 1'b0;
    cyc();
    cyc();
    en = 1'b1;

    // Block A, bin 0
    wait_sig(0, 10, ok);
    chk("a_clr_seen", ok, 1);
    chk("a_clr_cyc", ncyc, 7);
    chk("a_clr_coef", gz_coef, 18'h01234);
    chk("a_busy", busy, 1);
    cyc();
    chk("a_clr_width", gz_clr, 0);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_sig(1, 10, ok);
      chk("a_step_seen", ok, 1);
      chk("a_step_mic", mic_out, mic_val(ncyc - 1));
      if (k == 0) chk("a_step_first", ncyc, 10);
      else        chk("a_step_gap", ncyc - prev, 4);
      prev = ncyc;
      cyc();
      chk("a_step_width", gz_step, 0);
      chk("a_no_valid", res_valid, 0);
    end
    cyc();
    chk("a_valid", res_valid, 1);
    chk("a_res_bin", res_bin, 0);
    chk("a_res_y1", res_y1, y1m);
    chk("a_res_y2", res_y2, y2m);
`ifdef GZ_SCHED_DROP_CNT_EN
    chk("a_drop0", drop_cnt, 0);
`endif

    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("hold_valid", res_valid, 1);
      chk("hold_y1", res_y1, y1m);
      chk("hold_y2", res_y2, y2m);
      chk("hold_nostep", gz_step, 0);
    end
`ifdef GZ_SCHED_DROP_CNT_EN
    chk("hold_drop", drop_cnt, 3);
`endif

    // Block B, bin 1, with a mid-block write to its own table entry
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("b_clr", gz_clr, 1);
    chk("b_coef", gz_coef, 18'h00ABC);
    chk("b_valid_low", res_valid, 0);
    coef_we = 1'b1; coef_addr = 1'b1; coef_wdata = 18'h05555;
    cyc();
    coef_we = 1'b0;
    cyc();
    chk("b_coef_stable", gz_coef, 18'h00ABC);
    wait_sig(2, 40, ok);
    chk("b_valid_seen", ok, 1);
    chk("b_res_bin", res_bin, 1);
    chk("b_res_y1", res_y1, y1m);

    // Bin wraps back to 0
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("c_clr", gz_clr, 1);
    chk("c_coef", gz_coef, 18'h01234);

    // Block C: en dropped after the first step
    wait_sig(1, 20, ok);
    chk("c_step1_seen", ok, 1);
    en = 1'b0;
    nsteps = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (gz_step) nsteps++;
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("c_valid_seen", ok, 1);
    chk("c_more_steps", nsteps, 2);
    chk("c_res_bin", res_bin, 0);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("c_idle_busy", busy, 0);
    chk("c_idle_valid", res_valid, 0);
    cyc();
    chk("c_idle_busy2", busy, 0);
    chk("c_idle_clr", gz_clr, 0);

    // Block D, bin 1: mid-block write from block B now applies; reset during SETTLE
    en = 1'b1;
    wait_sig(0, 10, ok);
    chk("d_clr_seen", ok, 1);
    chk("d_coef_new", gz_coef, 18'h05555);
    for (int k = 0; k < 3; k++) begin
      wait_sig(1, 20, ok);
      chk("d_step_seen", ok, 1);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    en  = 1'b0;
    chk("r_valid", res_valid, 0);
    chk("r_busy", busy, 0);
    chk("r_coef", gz_coef, 0);
    chk("r_step", gz_step, 0);
    chk("r_mic", mic_out, 0);
`ifdef GZ_SCHED_DROP_CNT_EN
    chk("r_drop", drop_cnt, 0);
`endif
    en = 1'b1;
    wait_sig(0, 10, ok);
    chk("r_clr_seen", ok, 1);
    chk("r_tbl_cleared", gz_coef, 0);
    wait_sig(2, 40, ok);
    chk("r_valid_seen", ok, 1);
    chk("r_bin0", res_bin, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/goertzel_sched.md
GOERTZEL_SCHED -- requirements
Module: goertzel_sched

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5000: CLK cycles per sample tick (20 kHz at 100 MHz).
REQ-002 SHALL have parameter N_SAMPLES, default 205: samples per Goertzel block.
REQ-003 SHALL have parameter N_BINS, default 8: target frequencies scheduled round-robin.
REQ-004 SHALL have parameter SETTLE_CYC, default 2: cycles after the last step before results are captured.
REQ-005 SHALL have parameter COEF_W, default 18: coefficient width.
REQ-006 SHALL have ports: CLK in 1, system clock; RST in 1, reset. One clock; reset is synchronous and active-high.
REQ-007 SHALL have ports: en in 1, run scheduling; busy out 1, block in progress.
REQ-008 SHALL have ports: mic_in in 12, ADC sample; mic_out out 12, sample presented to datapath.
REQ-009 SHALL have ports: gz_clr out 1, datapath state clear; gz_step out 1, datapath consume strobe; gz_coef out COEF_W, active coefficient; gz_y1 in 61 and gz_y2 in 61, datapath state.
REQ-010 SHALL have ports: coef_we in 1; coef_addr in clog2(N_BINS); coef_wdata in COEF_W, coefficient table write.
REQ-011 SHALL have ports: res_valid out 1; res_ready in 1; res_bin out clog2(N_BINS); res_y1 out 61; res_y2 out 61.

Function
REQ-012 SHALL generate a 1-cycle internal tick when the free-running counter equals CLK_DIV-1; the counter then wraps to 0.
REQ-013 SHALL implement the FSM IDLE->CLEAR->ACCUM->SETTLE->OUTPUT. IDLE->CLEAR on en=1. CLEAR lasts 1 cycle. ACCUM->SETTLE after N_SAMPLES steps. SETTLE->OUTPUT after SETTLE_CYC cycles. OUTPUT->CLEAR (en=1) or IDLE (en=0) on the res_valid&&res_ready cycle.
REQ-014 SHALL, in CLEAR: pulse gz_clr for 1 cycle and load gz_coef from table[bin]; gz_coef SHALL remain stable until the next CLEAR.
REQ-015 SHALL, on each tick in ACCUM: register mic_in into mic_out and assert gz_step for exactly 1 cycle (both visible the cycle after the tick); mic_out SHALL hold between steps.
REQ-016 SHALL ignore ticks outside ACCUM (no gz_step).
REQ-017 SHALL, on SETTLE exit: capture gz_y1/gz_y2 into res_y1/res_y2, set res_bin=bin, and assert res_valid; outputs SHALL remain stable while res_valid && !res_ready.
REQ-018 SHALL, on handshake: clear res_valid and advance bin, wrapping N_BINS-1 -> 0.
REQ-019 SHALL, when en falls mid-block: complete the current block and its result handshake, then enter IDLE; bin SHALL still advance.
REQ-020 SHALL make coef_we writes effective the next cycle; a write to the active bin during a block SHALL take effect at its next CLEAR.
REQ-021 SHALL assert busy in every state except IDLE.

Reset
REQ-022 SHALL, on RST (any state, including mid-block): return to IDLE with tick counter 0, bin 0, sample count 0, all coefficient entries 0, and all outputs 0 the next cycle.

Configuration
REQ-023 SHALL, with GZ_SCHED_DROP_CNT_EN defined: add output drop_cnt (16 bits), a saturating count of ticks occurring while en=1 and state!=ACCUM, reset to 0. Without the macro, the port and logic SHALL be absent.

Structure
REQ-024 SHALL take from package goertzel_pkg: the state enum, MIC_W=12, Y_W=61, and COEF_W default.
REQ-025 SHALL place tick generation in sub-module sample_tick_gen (CLK, RST, tick).

Verification (CLK_DIV=4, N_SAMPLES=3, N_BINS=2, SETTLE_CYC=2)
REQ-026 SHALL be verified with: RST high 2 cycles -> all outputs 0, busy=0.
REQ-027 SHALL be verified with: table[0]=0x01234, table[1]=0x00ABC, en=1 -> 1 gz_clr with gz_coef=0x01234; 3 gz_step pulses 4 cycles apart with mic_out equal to mic_in at each tick; res_valid 2 cycles after the last step, res_bin=0, res_y1/res_y2 equal gz_y1/gz_y2.
REQ-028 SHALL be verified with: res_ready=0 for 12 cycles -> res_data stable, no gz_step; drop_cnt=3 with macro defined.
REQ-029 SHALL be verified with: accept bin 1 result -> next gz_clr has gz_coef=0x01234 and the next res_bin=0.
REQ-030 SHALL be verified with: en dropped after the 1st step -> 2 further steps, 1 result, then IDLE with busy=0.
REQ-031 SHALL be verified with: RST asserted during SETTLE -> next cycle res_valid=0, busy=0, bin 0, table cleared.
